pc_branch_unit: RTL
===================

Name: pc_branch_unit

Overview:
- Owns the LC-3 program counter and resolves control-flow instructions.
- Accepts one instruction word per handshake and drives the branch-condition mask (IR[11:9]) to the datapath's NZP condition evaluator.
- Samples that evaluator's single-bit branch-enable result and updates the PC with the fall-through, PC-relative or base-register target.
- Sits between the instruction-issue logic and the memory-address path.

Parameters:
PC_RESET, 16'h3000, PC value loaded on reset
OFFSET_W, 9, width of the BR PC-relative offset field (IR[OFFSET_W-1:0]), sign-extended

Ports:
clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
issue_valid  in  1  instruction word on ir is valid
issue_ready  out  1  block can accept an instruction
ir  in  16  instruction word
base_data  in  16  base register contents for JMP/RET, valid during EVAL
ben  in  1  branch enable from the NZP evaluator, sampled during EVAL
cc_mask  out  3  condition mask to the evaluator (registered IR[11:9])
pc  out  16  current program counter
pc_valid  out  1  one-cycle pulse: pc holds the resolved next PC
br_taken  out  1  registered, set with pc_valid when the PC was redirected
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, Reset=0): state=IDLE, pc=PC_RESET, ir_q=0, cc_mask=3'b000, pc_valid=0, br_taken=0, target=0; issue_ready=1, busy=0 once Reset deasserts.
- Reset asserted mid-operation aborts the instruction; no pc_valid pulse is issued for it.
- FSM states: IDLE -> EVAL -> UPDATE -> IDLE, one cycle each.
- IDLE: issue_ready=1.
  - On issue_valid=1 at a rising edge: ir_q<=ir, pc<=pc+1 (fetch increment, mod 2^16), go to EVAL.
  - issue_valid=0: stay in IDLE.
- EVAL: issue_ready=0, cc_mask=ir_q[11:9], so the evaluator output ben is valid in this cycle.
  - Opcode ir_q[15:12]=0000 (BR): target<=pc+sext(ir_q[8:0]); taken<=ben.
  - BR with ir_q[11:9]=000 is never taken, regardless of ben.
  - Opcode 1100 (JMP/RET): target<=base_data; taken<=1; ben is ignored.
  - Any other opcode: taken<=0.
  - Go to UPDATE.
- UPDATE: if taken, pc<=target, otherwise pc is unchanged.
  - pc_valid<=1 for exactly one cycle, aligned with the new pc value.
  - br_taken<=taken, held until the next pc_valid.
  - Go to IDLE.
- Arithmetic: all PC math is 16-bit and wraps modulo 2^16.
  - 16'hFFFF+1=16'h0000.
  - Negative offsets wrap below 16'h0000.
- Latency:
  - Accept at edge k.
  - pc+1 visible after edge k.
  - Resolved pc and pc_valid visible after edge k+2.
  - The next accept is possible at edge k+3.
- Throughput: one instruction per 3 cycles.
- Back-pressure:
  - issue_valid while issue_ready=0 is ignored and not queued.
  - The issuer must hold issue_valid until issue_ready.
- cc_mask holds ir_q[11:9] in all states; it changes only on accept.
- base_data and ben are don't-care outside EVAL.

Optional Feature:
- Macro: BR_STATS_EN.
- With BR_STATS_EN defined:
  - Adds output port taken_count [15:0], a count of UPDATE cycles with taken=1.
  - JMP is counted.
  - The counter wraps 16'hFFFF->16'h0000.
  - Async reset to 0.
- Without BR_STATS_EN: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, then issue ir=16'h1021 (ADD): pc=16'h3001 after accept, pc_valid pulses 2 cycles later, br_taken=0, pc stays 16'h3001.
- Issue BRz ir=16'h0405 (offset +5) at pc=16'h3000 with ben=1 in EVAL: cc_mask=3'b010, final pc=16'h3006, br_taken=1.
- Same instruction with ben=0: final pc=16'h3001, br_taken=0.
- BRnzp offset 9'h1FF (-1) at pc=16'h0000: pc goes 16'h0001 -> 16'h0000; separately, BR with mask 000 and ben forced 1: not taken.
- JMP ir=16'hC1C0 with base_data=16'h4000: final pc=16'h4000, br_taken=1; issue_valid held during EVAL/UPDATE is not accepted until IDLE.
- Assert Reset during EVAL: pc=PC_RESET immediately, no pc_valid pulse; with BR_STATS_EN, three taken branches give taken_count=3 and reset clears it to 0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// pc_branch_unit -- LC-3 program counter owner and control-flow resolver.
//
// Takes one instruction per issue handshake and steps it through a fixed
// IDLE -> EVAL -> UPDATE sequence, one cycle per state:
//   IDLE   : accept ir, latch it, fetch-increment pc.
//   EVAL   : the NZP evaluator sees cc_mask and returns ben; the branch target
//            and taken decision are captured.
//   UPDATE : pc is redirected if taken; pc_valid pulses for one cycle.
// All PC arithmetic is 16-bit and wraps.
//
// Ports:
//   clk, Reset (async, active low)
//   issue_valid / issue_ready : instruction handshake, ir is the word
//   base_data                 : base register for JMP/RET, sampled in EVAL
//   ben                       : branch enable from evaluator, sampled in EVAL
//   cc_mask                   : registered IR[11:9] to the evaluator
//   pc, pc_valid, br_taken    : program counter, resolve pulse, redirect flag
//   busy                      : high whenever not IDLE
//
// Optional feature (macro BR_STATS_EN): adds taken_count[15:0], a wrapping
// count of redirected PC updates (BR taken and JMP/RET).
module pc_branch_unit #(
  parameter logic [15:0] PC_RESET = 16'h3000,
  parameter int          OFFSET_W = 9
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [15:0] ir,
  input  logic [15:0] base_data,
  input  logic        ben,
  output logic [2:0]  cc_mask,
  output logic [15:0] pc,
  output logic        pc_valid,
  output logic        br_taken,
`ifdef BR_STATS_EN
  output logic [15:0] taken_count,
`endif
  output logic        busy
);

  localparam int EXT_W = 16 - OFFSET_W;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] ir_q;
  logic [15:0] target;
  logic        taken;
  logic [15:0] br_off;

  // Sign-extended PC-relative offset of the latched instruction.
  assign br_off = {{EXT_W{ir_q[OFFSET_W-1]}}, ir_q[OFFSET_W-1:0]};

  assign issue_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      pc       <= PC_RESET;
      ir_q     <= 16'h0000;
      cc_mask  <= 3'b000;
      target   <= 16'h0000;
      taken    <= 1'b0;
      pc_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      pc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid) begin
            ir_q    <= ir;
            cc_mask <= ir[11:9];
            pc      <= pc + 16'd1;
            state   <= EVAL;
          end
        end
        EVAL: begin
          // pc already holds the incremented value, so BR offsets are
          // relative to the instruction after the branch.
          case (ir_q[15:12])
            OP_BR: begin
              target <= pc + br_off;
              // An empty nzp mask can never be taken, whatever ben says.
              taken  <= ben && (ir_q[11:9] != 3'b000);
            end
            OP_JMP: begin
              target <= base_data;
              taken  <= 1'b1;
            end
            default: taken <= 1'b0;
          endcase
          state <= UPDATE;
        end
        UPDATE: begin
          if (taken) pc <= target;
          pc_valid <= 1'b1;
          br_taken <= taken;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)                       taken_count <= 16'h0000;
    else if (state == UPDATE && taken) taken_count <= taken_count + 16'd1;
  end
`endif

endmodule
